// File: rtl/instru_loader.sv
// Host-link program loader: parses framed byte stream, writes 32-bit LE words into instruction RAM.
// Optional checksum byte at frame end is enabled with `define LOADER_CHECKSUM_EN.
module instru_loader #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err,
  output logic [2:0]        dbg_state
);

  // Handshake: a byte is consumed on a rising edge where in_valid && in_ready;
  // in_ready depends only on the state, so it never combinationally follows in_valid.

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN0  = 3'd1,
    LEN1  = 3'd2,
    DATA  = 3'd3,
    WRITE = 3'd4,
    CHK   = 3'd5,
    DONE  = 3'd6,
    ERR   = 3'd7
  } state_t;

  localparam logic [7:0]  SYNC = 8'hA5;
  localparam int unsigned MAXW = MAX_WORDS;

  state_t      state_q, state_d;
  logic [15:0] count_q;
  logic [15:0] k_q;
  logic [1:0]  lane_q;
  logic [23:0] asm_q;
  logic        done_q, err_q;
  logic        accept, start, set_done, set_err;
  logic [15:0] len_n, k_inc;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  sum_q;
`endif

  assign accept = in_valid && in_ready;
  assign len_n  = {in_data, count_q[7:0]};
  assign k_inc  = k_q + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    set_done = 1'b0;
    set_err  = 1'b0;
    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (accept && in_data == SYNC) begin
          state_d = LEN0;
          start   = 1'b1;
        end
      end
      LEN0: if (accept) state_d = LEN1;
      LEN1: begin
        if (accept) begin
          if ({16'd0, len_n} > MAXW) begin
            state_d = ERR;
            set_err = 1'b1;
          end else if (len_n == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d  = CHK;
`else
            state_d  = DONE;
            set_done = 1'b1;
`endif
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: if (accept && lane_q == 2'd3) state_d = WRITE;
      WRITE: begin
        if (k_inc == count_q) begin
`ifdef LOADER_CHECKSUM_EN
          state_d  = CHK;
`else
          state_d  = DONE;
          set_done = 1'b1;
`endif
        end else begin
          state_d = DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        if (accept) begin
          if (in_data == sum_q) begin
            state_d  = DONE;
            set_done = 1'b1;
          end else begin
            state_d = ERR;
            set_err = 1'b1;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      k_q     <= '0;
      lane_q  <= '0;
      asm_q   <= '0;
      wr_data <= '0;
      wr_addr <= BASE_ADDR;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (start) begin
        k_q    <= '0;
        lane_q <= '0;
        done_q <= 1'b0;
        err_q  <= 1'b0;
      end
      if (set_done) done_q <= 1'b1;
      if (set_err)  err_q  <= 1'b1;
      if (state_q == LEN0 && accept) count_q[7:0]  <= in_data;
      if (state_q == LEN1 && accept) count_q[15:8] <= in_data;
      if (state_q == DATA && accept) begin
        lane_q <= lane_q + 2'd1;
        unique case (lane_q)
          2'd0: asm_q[7:0]   <= in_data;
          2'd1: asm_q[15:8]  <= in_data;
          2'd2: asm_q[23:16] <= in_data;
          default: begin
            // Output word/address only change here, so they hold between writes.
            wr_data <= {in_data, asm_q};
            wr_addr <= BASE_ADDR + ADDR_W'({k_q, 2'b00});
          end
        endcase
      end
      if (state_q == WRITE) k_q <= k_inc;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         sum_q <= '0;
    else if (start)                     sum_q <= '0;
    else if (state_q == DATA && accept) sum_q <= sum_q + in_data;
  end
`endif

  assign in_ready  = (state_q != WRITE);
  assign wr_en     = (state_q == WRITE);
  assign cpu_hold  = !(state_q == IDLE || state_q == DONE);
  assign load_busy = !(state_q == IDLE || state_q == DONE || state_q == ERR);
  assign load_done = done_q;
  assign load_err  = err_q;
  assign dbg_state = state_q;

endmodule
